regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 95 +++++++++
 tb/tb_regfile.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile: 2**ADDR_W x DATA_W register file, two combinational read ports and
// one synchronous write port. Register x0 is hardwired to zero. A write that is
// in flight this cycle is forwarded to any enabled read port whose address
// matches.
//
// Ports
//   clk       : single clock; writes on the rising edge
//   rst       : asynchronous reset, active low; clears every register
//   op1_addr  : read port 1 address
//   rd1_en    : read port 1 enable (op1 = 0 when low)
//   op1       : read port 1 data (combinational)
//   op2_addr  : read port 2 address
//   rd2_en    : read port 2 enable (op2 = 0 when low)
//   op2       : read port 2 data (combinational)
//   wr_addr   : write address
//   wr_data   : write data
//   wr_en     : write enable
// -----------------------------------------------------------------------------
module regfile #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] op1_addr,
   input  logic              rd1_en,
   output logic [DATA_W-1:0] op1,
   input  logic [ADDR_W-1:0] op2_addr,
   input  logic              rd2_en,
   output logic [DATA_W-1:0] op2,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en
);

   localparam int unsigned NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   // Qualified write: reset blocks writes and forwarding; x0 never accepts one.
   logic wr_valid;
   assign wr_valid = rst && wr_en && (wr_addr != ADDR_W'(0));

   // Next-state for the storage array.
   always_comb begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_valid) begin
         regs_d[wr_addr] = wr_data;
      end
      // x0 stays zero whatever happens above.
      regs_d[0] = '0;
   end

   // Storage array with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read port 1: forwarded write data wins over stored contents.
   always_comb begin
      op1 = '0;
      if (rst && rd1_en && (op1_addr != ADDR_W'(0))) begin
         if (wr_valid && (wr_addr == op1_addr)) begin
            op1 = wr_data;
         end else begin
            op1 = regs_q[op1_addr];
         end
      end
   end

   // Read port 2: same forwarding rule, evaluated independently.
   always_comb begin
      op2 = '0;
      if (rst && rd2_en && (op2_addr != ADDR_W'(0))) begin
         if (wr_valid && (wr_addr == op2_addr)) begin
            op2 = wr_data;
         end else begin
            op2 = regs_q[op2_addr];
         end
      end
   end

endmodule

// File: tb/tb_regfile.sv
// -----------------------------------------------------------------------------
// tb_regfile: directed self-checking bench for regfile (default 32 x 32).
// -----------------------------------------------------------------------------
module tb_regfile;

   logic        clk;
   logic        rst;
   logic [4:0]  op1_addr;
   logic        rd1_en;
   logic [31:0] op1;
   logic [4:0]  op2_addr;
   logic        rd2_en;
   logic [31:0] op2;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        wr_en;

   int checks;
   int errors;

   regfile #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .op1_addr (op1_addr),
      .rd1_en   (rd1_en),
      .op1      (op1),
      .op2_addr (op2_addr),
      .rd2_en   (rd2_en),
      .op2      (op2),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_en    (wr_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // One-cycle write: set up after a falling edge, commit on the next rising edge.
   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_addr = a;
      wr_data = d;
      wr_en   = 1'b1;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b0;
      op1_addr = 5'd1;
      rd1_en   = 1'b1;
      op2_addr = 5'd1;
      rd2_en   = 1'b1;
      // Write and forwarding conditions held during reset must have no effect.
      wr_addr  = 5'd1;
      wr_data  = 32'hFFFF_FFFF;
      wr_en    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_op1", op1, 32'h0);
      check("rst_op2", op2, 32'h0);

      // Release away from the rising edge.
      @(negedge clk);
      wr_en = 1'b0;
      rst   = 1'b1;
      #1;
      for (int i = 1; i < 32; i++) begin
         op1_addr = 5'(i);
         op2_addr = 5'(i);
         #1;
         check($sformatf("post_rst_op1_x%0d", i), op1, 32'h0);
         check($sformatf("post_rst_op2_x%0d", i), op2, 32'h0);
      end

      // Forwarding before the edge, stored value after it.
      @(negedge clk);
      op1_addr = 5'd1;
      rd1_en   = 1'b1;
      wr_addr  = 5'd1;
      wr_data  = 32'h0000_0FFF;
      wr_en    = 1'b1;
      #1;
      check("bypass_x1", op1, 32'h0000_0FFF);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      #1;
      check("stored_x1", op1, 32'h0000_0FFF);

      // x0 ignores writes and always reads zero, even with forwarding conditions met.
      @(negedge clk);
      op1_addr = 5'd0;
      op2_addr = 5'd0;
      rd1_en   = 1'b1;
      rd2_en   = 1'b1;
      wr_addr  = 5'd0;
      wr_data  = 32'hDEAD_BEEF;
      wr_en    = 1'b1;
      #1;
      check("x0_bypass_op1", op1, 32'h0);
      check("x0_bypass_op2", op2, 32'h0);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      #1;
      check("x0_stored_op1", op1, 32'h0);
      check("x0_stored_op2", op2, 32'h0);

      // Read enable gating.
      do_write(5'd5, 32'h1234_5678);
      op1_addr = 5'd5;
      rd1_en   = 1'b0;
      #1;
      check("x5_rd1_off", op1, 32'h0);
      rd1_en = 1'b1;
      #1;
      check("x5_rd1_on", op1, 32'h1234_5678);

      // Two ports reading different registers, top address included.
      do_write(5'd31, 32'hA5A5_A5A5);
      do_write(5'd2,  32'h5A5A_5A5A);
      op1_addr = 5'd31;
      op2_addr = 5'd2;
      #1;
      check("x31_op1", op1, 32'hA5A5_A5A5);
      check("x2_op2",  op2, 32'h5A5A_5A5A);

      // Forwarding to both ports at once, then only to the enabled one.
      @(negedge clk);
      op1_addr = 5'd7;
      op2_addr = 5'd7;
      wr_addr  = 5'd7;
      wr_data  = 32'hCAFE_F00D;
      wr_en    = 1'b1;
      #1;
      check("dual_bypass_op1", op1, 32'hCAFE_F00D);
      check("dual_bypass_op2", op2, 32'hCAFE_F00D);
      rd2_en = 1'b0;
      #1;
      check("bypass_rd2_off", op2, 32'h0);
      rd2_en = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      #1;
      check("x7_stored_op2", op2, 32'hCAFE_F00D);

      // Forwarding only to the matching port; the other keeps stored data.
      @(negedge clk);
      op1_addr = 5'd2;
      op2_addr = 5'd31;
      wr_addr  = 5'd2;
      wr_data  = 32'h0BAD_CAFE;
      wr_en    = 1'b1;
      #1;
      check("bypass_match_op1", op1, 32'h0BAD_CAFE);
      check("bypass_nomatch_op2", op2, 32'hA5A5_A5A5);
      @(posedge clk);
      #1;
      wr_en = 1'b0;

      // wr_en low leaves the register untouched.
      @(negedge clk);
      wr_addr  = 5'd5;
      wr_data  = 32'hFFFF_0000;
      wr_en    = 1'b0;
      op1_addr = 5'd5;
      @(posedge clk);
      #1;
      check("x5_no_write", op1, 32'h1234_5678);

      // Asynchronous reset mid-cycle.
      do_write(5'd3, 32'h0000_0001);
      op1_addr = 5'd3;
      op2_addr = 5'd5;
      #1;
      check("x3_before_rst", op1, 32'h0000_0001);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("x3_async_rst_op1", op1, 32'h0);
      check("x5_async_rst_op2", op2, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("x3_after_rst", op1, 32'h0);
      check("x5_after_rst", op2, 32'h0);
      op1_addr = 5'd31;
      op2_addr = 5'd7;
      #1;
      check("x31_after_rst", op1, 32'h0);
      check("x7_after_rst",  op2, 32'h0);

      // Normal operation resumes after release.
      do_write(5'd9, 32'h0F0F_0F0F);
      op1_addr = 5'd9;
      #1;
      check("x9_resume", op1, 32'h0F0F_0F0F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
